// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// an elaboration-time ceil(log2) helper used to size the sample counters.
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if (value > (32'sd1 << i)) begin
                result = i + 32'sd1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with a registered
// one-cycle pulse on each rising edge of the synchronized level.
module sync_edge (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic async_in,
    output logic sync_level,
    output logic sync_rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic rise_r;

    // Synchronizer chain plus previous-value register for edge detection
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
            rise_r <= sync_r & ~prev_r;
        end
    end

    assign sync_level = sync_r;
    assign sync_rise  = rise_r;

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw button against a slow sample strobe and produces a clean
// level plus press / release / hold / auto-repeat events, all on CLOCK.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4,
    parameter int HOLD_SAMPLES   = 100,
    parameter int REPEAT_SAMPLES = 20
) (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic SAMPLE_CLOCK,
    input  logic BTN_IN,
    output logic BTN_LEVEL,
    output logic BTN_PRESS,
    output logic BTN_RELEASE,
    output logic BTN_HOLD,
    output logic BTN_REPEAT
);

    localparam int STAB_W = clog2(STABLE_SAMPLES + 1);
    localparam int HOLD_W = clog2(HOLD_SAMPLES + 1);
    localparam int REP_W  = clog2(REPEAT_SAMPLES + 1);

    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_SAMPLES);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [STAB_W-1:0] STAB_ZERO = STAB_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_SAMPLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REPEAT_SAMPLES);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);
    localparam logic [REP_W-1:0]  REP_ZERO  = REP_W'(0);

    logic tick_s;
    logic btn_s;
    logic samp_level_unused_s;
    logic btn_rise_unused_s;

    sync_edge u_sample_sync (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .async_in   (SAMPLE_CLOCK),
        .sync_level (samp_level_unused_s),
        .sync_rise  (tick_s)
    );

    sync_edge u_button_sync (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .async_in   (BTN_IN),
        .sync_level (btn_s),
        .sync_rise  (btn_rise_unused_s)
    );

    state_t            state_r,    state_s;
    logic [STAB_W-1:0] stab_cnt_r, stab_cnt_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
    logic [REP_W-1:0]  rep_cnt_r,  rep_cnt_s;
    logic              level_r,    level_s;
    logic              hold_r,     hold_s;
    logic              press_r,    press_s;
    logic              release_r,  release_s;
    logic              repeat_r,   repeat_s;

    // Next-state and event decode; everything holds between sample ticks
    always_comb begin
        state_s    = state_r;
        stab_cnt_s = stab_cnt_r;
        hold_cnt_s = hold_cnt_r;
        rep_cnt_s  = rep_cnt_r;
        level_s    = level_r;
        hold_s     = hold_r;
        press_s    = 1'b0;
        release_s  = 1'b0;
        repeat_s   = 1'b0;
        if (tick_s) begin
            case (state_r)
                RELEASED: begin
                    if (btn_s) begin
                        if (STAB_MAX == STAB_ONE) begin
                            state_s    = PRESSED;
                            stab_cnt_s = STAB_ZERO;
                            level_s    = 1'b1;
                            press_s    = 1'b1;
                            hold_cnt_s = HOLD_ZERO;
                        end else begin
                            state_s    = PRESS_CHK;
                            stab_cnt_s = STAB_ONE;
                        end
                    end else begin
                        stab_cnt_s = STAB_ZERO;
                    end
                end
                PRESS_CHK: begin
                    if (btn_s) begin
                        if ((stab_cnt_r + STAB_ONE) == STAB_MAX) begin
                            state_s    = PRESSED;
                            stab_cnt_s = STAB_ZERO;
                            level_s    = 1'b1;
                            press_s    = 1'b1;
                            hold_cnt_s = HOLD_ZERO;
                        end else begin
                            stab_cnt_s = stab_cnt_r + STAB_ONE;
                        end
                    end else begin
                        state_s    = RELEASED;
                        stab_cnt_s = STAB_ZERO;
                    end
                end
                PRESSED: begin
                    if (btn_s) begin
                        // Hold counter saturates; repeat counting only starts once hold is set
                        if (hold_r) begin
                            if ((rep_cnt_r + REP_ONE) == REP_MAX) begin
                                repeat_s  = 1'b1;
                                rep_cnt_s = REP_ZERO;
                            end else begin
                                rep_cnt_s = rep_cnt_r + REP_ONE;
                            end
                        end else if ((hold_cnt_r + HOLD_ONE) == HOLD_MAX) begin
                            hold_cnt_s = HOLD_MAX;
                            hold_s     = 1'b1;
                            rep_cnt_s  = REP_ZERO;
                        end else begin
                            hold_cnt_s = hold_cnt_r + HOLD_ONE;
                        end
                    end else if (STAB_MAX == STAB_ONE) begin
                        state_s    = RELEASED;
                        stab_cnt_s = STAB_ZERO;
                        level_s    = 1'b0;
                        hold_s     = 1'b0;
                        release_s  = 1'b1;
                        hold_cnt_s = HOLD_ZERO;
                        rep_cnt_s  = REP_ZERO;
                    end else begin
                        state_s    = RELEASE_CHK;
                        stab_cnt_s = STAB_ONE;
                    end
                end
                RELEASE_CHK: begin
                    if (!btn_s) begin
                        if ((stab_cnt_r + STAB_ONE) == STAB_MAX) begin
                            state_s    = RELEASED;
                            stab_cnt_s = STAB_ZERO;
                            level_s    = 1'b0;
                            hold_s     = 1'b0;
                            release_s  = 1'b1;
                            hold_cnt_s = HOLD_ZERO;
                            rep_cnt_s  = REP_ZERO;
                        end else begin
                            stab_cnt_s = stab_cnt_r + STAB_ONE;
                        end
                    end else begin
                        state_s    = PRESSED;
                        stab_cnt_s = STAB_ZERO;
                    end
                end
                default: begin
                    state_s    = RELEASED;
                    stab_cnt_s = STAB_ZERO;
                    hold_cnt_s = HOLD_ZERO;
                    rep_cnt_s  = REP_ZERO;
                    level_s    = 1'b0;
                    hold_s     = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, counter and registered-output update
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r    <= RELEASED;
            stab_cnt_r <= STAB_ZERO;
            hold_cnt_r <= HOLD_ZERO;
            rep_cnt_r  <= REP_ZERO;
            level_r    <= 1'b0;
            hold_r     <= 1'b0;
            press_r    <= 1'b0;
            release_r  <= 1'b0;
            repeat_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            stab_cnt_r <= stab_cnt_s;
            hold_cnt_r <= hold_cnt_s;
            rep_cnt_r  <= rep_cnt_s;
            level_r    <= level_s;
            hold_r     <= hold_s;
            press_r    <= press_s;
            release_r  <= release_s;
            repeat_r   <= repeat_s;
        end
    end

    assign BTN_LEVEL   = level_r;
    assign BTN_PRESS   = press_r;
    assign BTN_RELEASE = release_r;
    assign BTN_HOLD    = hold_r;
    assign BTN_REPEAT  = repeat_r;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: one sample period per step, pulses counted per period and
// level/hold compared against hand-computed values after each tick.
module tb_button_debouncer;

    logic CLOCK;
    logic RESET_N;
    logic SAMPLE_CLOCK;
    logic BTN_IN;
    logic BTN_LEVEL;
    logic BTN_PRESS;
    logic BTN_RELEASE;
    logic BTN_HOLD;
    logic BTN_REPEAT;

    int checks_n;
    int errors_n;
    int step_n;

    button_debouncer #(
        .STABLE_SAMPLES (3),
        .HOLD_SAMPLES   (5),
        .REPEAT_SAMPLES (2)
    ) dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .SAMPLE_CLOCK (SAMPLE_CLOCK),
        .BTN_IN       (BTN_IN),
        .BTN_LEVEL    (BTN_LEVEL),
        .BTN_PRESS    (BTN_PRESS),
        .BTN_RELEASE  (BTN_RELEASE),
        .BTN_HOLD     (BTN_HOLD),
        .BTN_REPEAT   (BTN_REPEAT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors_n++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sample period: SAMPLE_CLOCK low 4 cycles then high 4 cycles with BTN_IN held
    task automatic step(input logic b, input int e_press, input int e_rel, input int e_rep,
                        input logic e_level, input logic e_hold);
        int n_press;
        int n_rel;
        int n_rep;
        n_press = 0;
        n_rel   = 0;
        n_rep   = 0;
        step_n++;
        BTN_IN       = b;
        SAMPLE_CLOCK = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLOCK);
            #1;
            n_press += int'(BTN_PRESS);
            n_rel   += int'(BTN_RELEASE);
            n_rep   += int'(BTN_REPEAT);
            if (i == 3) SAMPLE_CLOCK = 1'b1;
        end
        check($sformatf("t%0d.press", step_n), n_press, e_press);
        check($sformatf("t%0d.release", step_n), n_rel, e_rel);
        check($sformatf("t%0d.repeat", step_n), n_rep, e_rep);
        check($sformatf("t%0d.level", step_n), {31'd0, BTN_LEVEL}, {31'd0, e_level});
        check($sformatf("t%0d.hold", step_n), {31'd0, BTN_HOLD}, {31'd0, e_hold});
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge CLOCK);
        RESET_N      = 1'b0;
        SAMPLE_CLOCK = 1'b0;
        #1;
        check({tag, ".level"}, {31'd0, BTN_LEVEL}, 32'd0);
        check({tag, ".hold"}, {31'd0, BTN_HOLD}, 32'd0);
        check({tag, ".pulses"}, {29'd0, BTN_PRESS, BTN_RELEASE, BTN_REPEAT}, 32'd0);
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b1;
    endtask

    initial begin
        checks_n     = 0;
        errors_n     = 0;
        step_n       = 0;
        RESET_N      = 1'b0;
        SAMPLE_CLOCK = 1'b0;
        BTN_IN       = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        check("reset.level", {31'd0, BTN_LEVEL}, 32'd0);
        check("reset.hold", {31'd0, BTN_HOLD}, 32'd0);
        check("reset.pulses", {29'd0, BTN_PRESS, BTN_RELEASE, BTN_REPEAT}, 32'd0);
        @(negedge CLOCK);
        RESET_N = 1'b1;

        step(1'b0, 0, 0, 0, 1'b0, 1'b0);
        // Clean press, accepted on the third tick
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1, 0, 0, 1'b1, 1'b0);
        // Hold five ticks, then repeat every two ticks
        for (int i = 0; i < 4; i++) step(1'b1, 0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 0, 0, 0, 1'b1, 1'b1);
        step(1'b1, 0, 0, 0, 1'b1, 1'b1);
        step(1'b1, 0, 0, 1, 1'b1, 1'b1);
        step(1'b1, 0, 0, 0, 1'b1, 1'b1);
        step(1'b1, 0, 0, 1, 1'b1, 1'b1);
        // One-tick release glitch with rep_cnt at 1: count resumes, no release
        step(1'b1, 0, 0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 0, 0, 1'b1, 1'b1);
        step(1'b1, 0, 0, 0, 1'b1, 1'b1);
        step(1'b1, 0, 0, 1, 1'b1, 1'b1);
        // Stable release: level and hold drop together
        step(1'b0, 0, 0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 1, 0, 1'b0, 1'b0);
        // Glitch before hold: hold_cnt frozen at 2, resumes to 5
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1, 0, 0, 1'b1, 1'b0);
        step(1'b1, 0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 0, 0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 1, 0, 1'b0, 1'b0);
        // Bounce across ticks: nothing accepted, stability count restarts
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1, 0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1, 0, 1'b0, 1'b0);
        // Reset in PRESS_CHK: a fresh three-tick press is needed
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        reset_pulse("rst_chk");
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1, 0, 0, 1'b1, 1'b0);
        // Reset in PRESSED: outputs clear at once, press re-qualified
        step(1'b1, 0, 0, 0, 1'b1, 1'b0);
        reset_pulse("rst_pressed");
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 1, 0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule
